// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared command/state types and frame layout for the UART program loader
package uart_loader_pkg;
    typedef enum logic [1:0] {
        CMD_SET_ADDR = 2'b00,
        CMD_WRITE    = 2'b01,
        CMD_RUN      = 2'b10,
        CMD_HALT     = 2'b11
    } cmd_t;
    typedef enum logic {S_IDLE, S_WRITE} ldr_state_t;
    localparam int FRAME_W = 34;
    localparam int CMD_MSB = 33;
    localparam int CMD_LSB = 32;
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: small synchronous FIFO; a push into a full FIFO succeeds when a pop frees a slot in the same cycle
module loader_fifo import uart_loader_pkg::*; #(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // Pointers carry one extra wrap bit to tell full from empty
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_rx_loader.sv
// uart_rx_loader: decodes UART frames into Avalon-MM word writes and core reset control
module uart_rx_loader import uart_loader_pkg::*; #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Rx_DV,
    input  logic [FRAME_W-1:0]   i_Rx_Word,
    output logic [31:0]          o_avm_address,
    output logic [31:0]          o_avm_writedata,
    output logic [3:0]           o_avm_byteenable,
    output logic                 o_avm_write,
    input  logic                 i_avm_waitrequest,
    output logic                 o_Cpu_Reset_n,
    output logic [CNT_WIDTH-1:0] o_Word_Count,
    output logic                 o_Overflow
);
    ldr_state_t state, state_next;
    logic [FRAME_W-1:0] head;
    logic [31:0] addr_reg, payload;
    logic full, empty, pop, accept;
    cmd_t cmd;
    loader_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(i_Clock), .rst_n(i_Reset_n), .push(i_Rx_DV), .pop(pop),
        .din(i_Rx_Word), .dout(head), .full(full), .empty(empty)
    );
    assign cmd              = cmd_t'(head[CMD_MSB:CMD_LSB]);
    assign payload          = head[31:0];
    assign o_avm_byteenable = 4'hF;
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) state <= S_IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state == S_IDLE ? ((pop && cmd == CMD_WRITE) ? S_WRITE : S_IDLE)
                                     : (accept ? S_IDLE : S_WRITE);
    end
    always_comb begin
        pop         = state == S_IDLE && !empty;
        o_avm_write = state == S_WRITE;
        accept      = o_avm_write && !i_avm_waitrequest;
    end
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            addr_reg        <= BASE_ADDR;
            o_avm_address   <= BASE_ADDR;
            o_avm_writedata <= '0;
            o_Cpu_Reset_n   <= 1'b0;
            o_Word_Count    <= '0;
            o_Overflow      <= 1'b0;
        end else begin
            if (i_Rx_DV && full && !pop) o_Overflow <= 1'b1;
            if (pop) begin
                case (cmd)
                    CMD_SET_ADDR: addr_reg <= {payload[31:2], 2'b00};
                    CMD_WRITE: begin
                        o_avm_address   <= addr_reg;
                        o_avm_writedata <= payload;
                    end
                    CMD_RUN:  o_Cpu_Reset_n <= 1'b1;
                    CMD_HALT: o_Cpu_Reset_n <= 1'b0;
                    default:  ;
                endcase
            end
            if (accept) begin
                addr_reg <= addr_reg + 32'd4;
                if (!(&o_Word_Count)) o_Word_Count <= o_Word_Count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader: table vectors, directed stall/reset sequences and a randomized
// transaction-level reference model for the UART program loader
module tb_uart_rx_loader;
    import uart_loader_pkg::*;

    logic        clk = 0, rst_n = 0, rx_dv = 0, wait_r = 0, rand_wait = 0;
    logic [33:0] rx_word = '0;
    logic [31:0] avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write, cpu_reset_n, overflow;
    logic [15:0] word_count;

    int checks = 0, errors = 0;
    logic [63:0] wq[$];

    uart_rx_loader dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Word(rx_word),
        .o_avm_address(avm_address), .o_avm_writedata(avm_writedata),
        .o_avm_byteenable(avm_byteenable), .o_avm_write(avm_write),
        .i_avm_waitrequest(wait_r), .o_Cpu_Reset_n(cpu_reset_n),
        .o_Word_Count(word_count), .o_Overflow(overflow)
    );

    always #5 clk = ~clk;

    // Accepted writes are recorded at the negedge preceding the accepting posedge
    always @(negedge clk) if (rst_n && avm_write && !wait_r) wq.push_back({avm_address, avm_writedata});

    always @(posedge clk) if (rand_wait) begin #1; wait_r = ($urandom_range(0, 3) == 0); end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [1:0] c, input logic [31:0] p);
        rx_dv = 1; rx_word = {c, p};
        tick();
        rx_dv = 0; rx_word = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; tick(2);
        wq.delete();
        rst_n = 1;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wq.size() < n && t < 500) begin tick(); t++; end
        if (wq.size() < n) chk("write_timeout", wq.size(), n);
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] pay;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_cpu;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t vecs[8];

    initial begin
        logic [31:0] m_addr, p, ea, ed;
        logic [15:0] m_cnt;
        logic        m_cpu;
        logic [1:0]  c;
        int          bad, n_exp;

        vecs[0] = '{2'b00, 32'h0000_1003, 32'h0,          32'h0,          1'b0, 16'd0};
        vecs[1] = '{2'b01, 32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 16'd1};
        vecs[2] = '{2'b01, 32'h0000_0011, 32'h0000_1004, 32'h0000_0011, 1'b0, 16'd2};
        vecs[3] = '{2'b10, 32'h0,          32'h0000_1004, 32'h0000_0011, 1'b1, 16'd2};
        vecs[4] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_1004, 32'h0000_0011, 1'b1, 16'd2};
        vecs[5] = '{2'b01, 32'h0000_0022, 32'hFFFF_FFFC, 32'h0000_0022, 1'b1, 16'd3};
        vecs[6] = '{2'b01, 32'h0000_0033, 32'h0000_0000, 32'h0000_0033, 1'b1, 16'd4};
        vecs[7] = '{2'b11, 32'h0,          32'h0000_0000, 32'h0000_0033, 1'b0, 16'd4};

        // Reset state
        rst_n = 0; tick(2);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_data", avm_writedata, 0);
        chk("rst_cpu", cpu_reset_n, 0);
        chk("rst_cnt", word_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("byteenable", avm_byteenable, 4'hF);
        rst_n = 1; tick();

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].cmd, vecs[i].pay);
            tick(3);
            chk($sformatf("vec%0d_addr", i), avm_address, vecs[i].e_addr);
            chk($sformatf("vec%0d_data", i), avm_writedata, vecs[i].e_data);
            chk($sformatf("vec%0d_cpu", i), cpu_reset_n, vecs[i].e_cpu);
            chk($sformatf("vec%0d_cnt", i), word_count, vecs[i].e_cnt);
        end
        chk("vec_nwrites", wq.size(), 4);

        // Three back-to-back writes
        do_reset();
        send(2'b01, 32'h11); send(2'b01, 32'h22); send(2'b01, 32'h33);
        wait_writes(3); tick(2);
        for (int i = 0; i < 3; i++) if (wq.size() > 0) chk($sformatf("b2b_w%0d", i), wq.pop_front(), {32'(i * 4), 32'(8'h11 * (i + 1))});
        chk("b2b_cnt", word_count, 3);
        chk("b2b_ovf", overflow, 0);

        // Stall with FIFO filling to capacity, then one more frame to overflow
        for (int ov = 0; ov < 2; ov++) begin
            do_reset();
            wait_r = 1;
            send(2'b01, 32'hA0); tick();
            send(2'b01, 32'hA1); send(2'b01, 32'hA2);
            if (ov == 1) send(2'b01, 32'hA3);
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                if (!(avm_write && avm_address == 0 && avm_writedata == 32'hA0)) bad++;
                tick();
            end
            chk($sformatf("stall%0d_stable", ov), bad, 0);
            chk($sformatf("stall%0d_nowrite", ov), wq.size(), 0);
            wait_r = 0;
            wait_writes(3); tick(20);
            chk($sformatf("stall%0d_nwrites", ov), wq.size(), 3);
            for (int i = 0; i < 3; i++) if (wq.size() > 0) chk($sformatf("stall%0d_w%0d", ov, i), wq.pop_front(), {32'(i * 4), 32'hA0 + 32'(i)});
            chk($sformatf("stall%0d_ovf", ov), overflow, ov);
            chk($sformatf("stall%0d_cnt", ov), word_count, 3);
        end

        // RUN and HALT queued behind a stalled write
        do_reset();
        wait_r = 1;
        send(2'b01, 32'h5A); send(2'b10, 0); send(2'b11, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin if (cpu_reset_n) bad++; tick(); end
        chk("run_held", bad, 0);
        wait_r = 0;
        tick(); chk("run_acc_cpu", cpu_reset_n, 0); chk("run_acc_nw", wq.size(), 1);
        tick(); chk("run_cpu_hi", cpu_reset_n, 1);
        tick(); chk("halt_cpu_lo", cpu_reset_n, 0);

        // Reset during a stalled write
        do_reset();
        send(2'b10, 0);
        wait_r = 1;
        send(2'b01, 32'h55); send(2'b01, 32'h66);
        tick(4);
        chk("mid_pre_write", avm_write, 1);
        rst_n = 0; tick();
        chk("mid_write", avm_write, 0);
        chk("mid_cnt", word_count, 0);
        chk("mid_cpu", cpu_reset_n, 0);
        chk("mid_addr", avm_address, 0);
        rst_n = 1; wait_r = 0; wq.delete();
        tick(6);
        chk("mid_fifo_empty", wq.size(), 0);
        send(2'b01, 32'h77);
        wait_writes(1);
        if (wq.size() > 0) chk("mid_after", wq.pop_front(), {32'h0, 32'h77});

        // Randomized frames against a transaction-level model
        do_reset();
        m_addr = 0; m_cnt = 0; m_cpu = 0; n_exp = 0;
        rand_wait = 1;
        for (int i = 0; i < 300; i++) begin
            c = 2'($urandom_range(0, 3));
            p = $urandom();
            send(c, p);
            case (c)
                2'b00: m_addr = {p[31:2], 2'b00};
                2'b01: begin
                    ea = m_addr; ed = p;
                    m_addr = m_addr + 4;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
                2'b10: m_cpu = 1;
                default: m_cpu = 0;
            endcase
            if (c == 2'b01) begin
                wait_writes(1); tick();
                if (wq.size() > 0) chk($sformatf("rnd%0d_write", i), wq.pop_front(), {ea, ed});
            end else tick(3);
            chk($sformatf("rnd%0d_cpu", i), cpu_reset_n, m_cpu);
            chk($sformatf("rnd%0d_cnt", i), word_count, m_cnt);
        end
        rand_wait = 0;
        chk("rnd_ovf", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
